serial_addsub: RTL and testbench
================================

SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand and result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, meaning bits processed per clock cycle; N = WIDTH/CHUNK.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset: asynchronous, active-high.
REQ-005 SHALL have port start, input, 1, meaning request to capture operands and begin an operation.
REQ-006 SHALL have port sub, input, 1, meaning 0 = add, 1 = subtract; captured with start.
REQ-007 SHALL have ports a and b, each input, WIDTH, meaning the operands; captured with start.
REQ-008 SHALL have port cin, input, 1, meaning carry-in (add) or borrow-in (subtract); captured with start.
REQ-009 SHALL have port busy, output, 1, meaning an operation is in progress.
REQ-010 SHALL have port done, output, 1, meaning a one-cycle pulse marking a valid result.
REQ-011 SHALL have port sum, output, WIDTH, meaning the result.
REQ-012 SHALL have port cout, output, 1, meaning carry out of the MSB; for subtract, 1 = no borrow.
REQ-013 SHALL have port ovf, output, 1, meaning two's-complement signed overflow.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 In IDLE or DONE, SHALL capture a, b, sub and cin, clear the chunk index, and enter RUN at an edge where start=1.
REQ-016 Without start, SHALL go DONE->IDLE and stay in IDLE.
REQ-017 In RUN, SHALL process chunk index i (bits i*CHUNK+CHUNK-1 : i*CHUNK) at each edge and then increment i.
REQ-018 SHALL pass the chunk carry through a register between chunks; the first chunk's carry-in SHALL be cin XOR sub.
REQ-019 SHALL use the B operand for every chunk as b (add) or ~b (subtract), giving a+b+cin or a-b-cin.
REQ-020 After the edge that processes chunk N-1, SHALL enter DONE.
REQ-021 Latency: start captured at edge k gives done=1 for exactly the cycle between edges k+N and k+N+1.
REQ-022 busy SHALL equal (state==RUN); done SHALL equal (state==DONE); both SHALL be register-driven.
REQ-023 SHALL set cout to the carry out of bit WIDTH-1, and ovf to carry-into-MSB XOR carry-out-of-MSB; both SHALL be registered at the last chunk.
REQ-024 sum, cout and ovf SHALL be valid while done=1 and SHALL hold until the next start is captured; their values during RUN are undefined for checking.
REQ-025 SHALL ignore start while in RUN; inputs SHALL not be sampled in RUN.
REQ-026 SHALL accept start in DONE (back-to-back), which gives the next done N cycles later.
REQ-027 SHALL produce a compile-time error if WIDTH%CHUNK != 0 or CHUNK < 1; CHUNK == WIDTH (N=1) SHALL be legal.

Reset
REQ-028 On rst=1, SHALL immediately force state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, index=0 and carry register=0.
REQ-029 SHALL abort an operation on rst asserted mid-RUN, with no done pulse and no partial result visible after reset.
REQ-030 SHALL leave start ignored while rst=1; the first capture SHALL occur at the first edge after rst deasserts.

Structure
REQ-031 SHALL place the FSM state typedef/encoding (IDLE=0, RUN=1, DONE=2) and the default WIDTH/CHUNK constants in shared package adder_pkg.
REQ-032 SHALL put the combinational CHUNK-bit ripple full-adder slice in one sub-module, fa_chunk (inputs a, b, ci; outputs s, co, c_msb), instantiated once and reused each cycle.

Verification (WIDTH=8, CHUNK=4, N=2 unless stated)
REQ-033 add a=FF, b=01, cin=0, start at edge k -> done high after edge k+2 only; sum=00, cout=1, ovf=0; busy high for 2 cycles.
REQ-034 add a=7F, b=01, cin=0 -> sum=80, cout=0, ovf=1; then add a=7F, b=00, cin=1 -> sum=80, ovf=1.
REQ-035 sub a=05, b=07, cin=0 -> sum=FE, cout=0, ovf=0; sub a=80, b=01, cin=0 -> sum=7F, cout=1, ovf=1.
REQ-036 start re-asserted during RUN with new operands -> ignored, result reflects the first operands; start during DONE -> second done exactly 2 cycles later with the correct result.
REQ-037 rst asserted after the first RUN edge -> done never pulses, outputs read 0; the next start after release completes normally.
REQ-038 CHUNK=8 (N=1): add a=C8, b=64 -> done one cycle after capture, sum=2C, cout=1, ovf=0; randomized 1000-op compare against a reference model for both configurations.

Source files
------------

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared FSM encoding and default sizing for the serial adder/subtractor
// Contents:
//   state_t        : FSM state type (IDLE=0, RUN=1, DONE=2)
//   DEFAULT_WIDTH  : default operand/result width in bits
//   DEFAULT_CHUNK  : default number of bits processed per clock
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CHUNK = 4;

endpackage

// File: rtl/fa_chunk.sv
// rtl/fa_chunk.sv - combinational CHUNK-bit ripple full-adder slice
// Ports:
//   a, b  : CHUNK-bit addend slices
//   ci    : carry into bit 0 of the slice
//   s     : CHUNK-bit sum slice
//   co    : carry out of the slice MSB
//   c_msb : carry into the slice MSB (used for signed overflow on the top chunk)
module fa_chunk
    import adder_pkg::*;
#(
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    always_comb begin : ripple
        logic [CHUNK:0] c;
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co    = c[CHUNK];
        c_msb = c[CHUNK-1];
    end

endmodule

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - multi-cycle adder/subtractor processing CHUNK bits per clock
// Ports:
//   clk   : clock, all state updates on its rising edge
//   rst   : asynchronous active-high reset
//   start : capture operands and begin an operation (honoured in IDLE or DONE)
//   sub   : 0 = a+b+cin, 1 = a-b-cin
//   a, b  : WIDTH-bit operands
//   cin   : carry-in (add) or borrow-in (subtract)
//   busy  : operation in progress
//   done  : one-cycle pulse, result valid
//   sum   : WIDTH-bit result, held until the next capture
//   cout  : carry out of the MSB (subtract: 1 = no borrow)
//   ovf   : two's-complement signed overflow
module serial_addsub
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N     = (CHUNK >= 1) ? WIDTH / CHUNK : 1;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    generate
        if (CHUNK < 1) begin : g_bad_chunk
            $error("serial_addsub: CHUNK must be at least 1");
        end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
            $error("serial_addsub: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [CHUNK-1:0]       fa_s;
    logic                   fa_co;
    logic                   fa_c_msb;
    logic [WIDTH+CHUNK-1:0] sum_cat;

    // Operands are shifted right each RUN cycle so the slice always sees the
    // low CHUNK bits; the result is shifted in from the top so after N cycles
    // chunk 0 has arrived at bit 0.
    fa_chunk #(
        .CHUNK (CHUNK)
    ) u_fa_chunk (
        .a     (a_q[CHUNK-1:0]),
        .b     (b_q[CHUNK-1:0]),
        .ci    (carry_q),
        .s     (fa_s),
        .co    (fa_co),
        .c_msb (fa_c_msb)
    );

    assign sum_cat = {fa_s, sum_q};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    a_d     = a;
                    // Subtract is a + ~b + 1 - cin, so invert b once here and
                    // seed the chain with cin ^ sub.
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = cin ^ sub;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = fa_co;
                sum_d   = sum_cat[WIDTH+CHUNK-1:CHUNK];
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST) begin
                    state_d = DONE;
                    cout_d  = fa_co;
                    ovf_d   = fa_co ^ fa_c_msb;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - self-checking bench for serial_addsub at WIDTH=8 with CHUNK=4 and CHUNK=8
module tb_serial_addsub;

    logic       clk;
    logic       rst;

    logic       start2, sub2, cin2;
    logic [7:0] a2, b2;
    logic       busy2, done2, cout2, ovf2;
    logic [7:0] sum2;

    logic       start1, sub1, cin1;
    logic [7:0] a1, b1;
    logic       busy1, done1, cout1, ovf1;
    logic [7:0] sum1;

    int n_assert;
    int n_fail;

    serial_addsub #(.WIDTH(8), .CHUNK(4)) u_n2 (
        .clk   (clk),
        .rst   (rst),
        .start (start2),
        .sub   (sub2),
        .a     (a2),
        .b     (b2),
        .cin   (cin2),
        .busy  (busy2),
        .done  (done2),
        .sum   (sum2),
        .cout  (cout2),
        .ovf   (ovf2)
    );

    serial_addsub #(.WIDTH(8), .CHUNK(8)) u_n1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .sub   (sub1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1),
        .ovf   (ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic. Returns {cout, ovf, sum}.
    function automatic logic [9:0] ref_model(input logic s, input logic [7:0] a, input logic [7:0] b,
                                             input logic ci);
        int ua, ub, sa, sb, ures, sres;
        logic co, ov;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        if (s) begin
            ures = ua - ub - int'(ci);
            sres = sa - sb - int'(ci);
            co   = (ures >= 0);
        end else begin
            ures = ua + ub + int'(ci);
            sres = sa + sb + int'(ci);
            co   = (ures > 255);
        end
        ov = (sres > 127) || (sres < -128);
        return {co, ov, 8'(ures & 255)};
    endfunction

    // {busy, done, cout, ovf, sum}
    function automatic logic [11:0] outs(input int cfg);
        if (cfg == 1) return {busy1, done1, cout1, ovf1, sum1};
        return {busy2, done2, cout2, ovf2, sum2};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int cfg, input logic st, input logic s, input logic [7:0] a,
                          input logic [7:0] b, input logic ci);
        if (cfg == 1) begin
            start1 = st; sub1 = s; a1 = a; b1 = b; cin1 = ci;
        end else begin
            start2 = st; sub2 = s; a2 = a; b2 = b; cin2 = ci;
        end
    endtask

    // Drives start now (just after an edge), checks busy/done every cycle up to
    // the done pulse, the result at the pulse, and that it holds through gap idle
    // cycles. With poke set, start is re-asserted with junk operands during RUN.
    task automatic op(input int cfg, input logic s, input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input bit poke, input int gap);
        int n;
        logic [9:0]  exp;
        logic [11:0] o;
        n   = (cfg == 1) ? 1 : 2;
        exp = ref_model(s, a, b, ci);
        set_in(cfg, 1'b1, s, a, b, ci);
        @(posedge clk);
        #1;
        o = outs(cfg);
        check("busy after capture", 32'(o[11]), 32'(n > 0));
        check("done after capture", 32'(o[10]), 32'd0);
        set_in(cfg, poke, 8'($urandom) & 8'h01, 8'($urandom), 8'($urandom), 1'($urandom));
        for (int c = 1; c <= n; c++) begin
            @(posedge clk);
            #1;
            o = outs(cfg);
            if (c < n) begin
                check("busy in run", 32'(o[11]), 32'd1);
                check("done in run", 32'(o[10]), 32'd0);
                set_in(cfg, poke, 8'($urandom) & 8'h01, 8'($urandom), 8'($urandom), 1'($urandom));
            end else begin
                check("busy at done", 32'(o[11]), 32'd0);
                check("done pulse", 32'(o[10]), 32'd1);
                check("sum", 32'(o[7:0]), 32'(exp[7:0]));
                check("cout", 32'(o[9]), 32'(exp[9]));
                check("ovf", 32'(o[8]), 32'(exp[8]));
                set_in(cfg, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
            end
        end
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
            o = outs(cfg);
            check("done idle", 32'(o[10]), 32'd0);
            check("busy idle", 32'(o[11]), 32'd0);
            check("hold result", 32'(o[9:0]), 32'(exp));
        end
    endtask

    initial begin
        logic [11:0] o;
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        set_in(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        set_in(2, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        #2;
        check("reset n2 outputs", 32'(outs(2)), 32'd0);
        check("reset n1 outputs", 32'(outs(1)), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vectors, N=2
        op(2, 1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, 1);
        op(2, 1'b0, 8'h7F, 8'h01, 1'b0, 1'b0, 0);
        op(2, 1'b0, 8'h7F, 8'h00, 1'b1, 1'b0, 0);
        op(2, 1'b1, 8'h05, 8'h07, 1'b0, 1'b0, 1);
        op(2, 1'b1, 8'h80, 8'h01, 1'b0, 1'b0, 2);
        // start re-asserted in RUN is ignored, then a back-to-back start in DONE
        op(2, 1'b0, 8'h12, 8'h34, 1'b1, 1'b1, 0);
        op(2, 1'b1, 8'h00, 8'h01, 1'b1, 1'b0, 1);

        // Reset after the first RUN edge aborts; start held during reset is ignored
        set_in(2, 1'b1, 1'b0, 8'hAB, 8'hCD, 1'b0);
        @(posedge clk);
        #1;
        set_in(2, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_in(2, 1'b1, 1'b0, 8'h55, 8'h22, 1'b1);
        #1;
        check("async reset clears", 32'(outs(2)), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            o = outs(2);
            check("no activity in reset", 32'(o), 32'd0);
        end
        rst = 1'b0;
        op(2, 1'b0, 8'h55, 8'h22, 1'b1, 1'b0, 1);

        // Directed, N=1
        op(1, 1'b0, 8'hC8, 8'h64, 1'b0, 1'b0, 1);
        op(1, 1'b1, 8'h80, 8'h01, 1'b0, 1'b0, 0);
        op(1, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 1);

        // Randomized comparison for both configurations
        for (int cfg = 1; cfg <= 2; cfg++) begin
            for (int i = 0; i < 1000; i++) begin
                op(cfg, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
